data_memory: RTL and testbench
==============================

// Module: data_memory
// PURPOSE
//  Word-addressed 16-bit data memory for the CPU-16 datapath (MEM stage).
//  Synchronous write on the rising Clock edge; combinational (asynchronous) read gated by MemRead.
//  Sits between the ALU address result and the register-file write-back mux.
// PARAMETERS
//  DATA_W  16   data word width (bits)
//  ADDR_W  16   width of the Adresa port
//  DEPTH   256  number of stored words; must be a power of two, at most 2**ADDR_W
// PORTS
//  Clock      in   1       single clock, rising edge
//  Reset      in   1       synchronous, active-high reset
//  Adresa     in   ADDR_W  word address
//  WriteData  in   DATA_W  data to store
//  MemWrite   in   1       write enable, sampled on the rising Clock edge
//  MemRead    in   1       read enable, combinational
//  ReadData   out  DATA_W  read data
//  AddrErr    out  1       only with DMEM_RANGE_CHECK_EN; see CONFIGURATION
// BEHAVIOUR
//  - Interface: one clock, Clock; synchronous active-high reset, Reset.
//  - Index = Adresa[log2(DEPTH)-1:0]. Upper address bits are ignored, so addresses wrap modulo DEPTH.
//  - Reset (rising Clock edge with Reset=1): every word clears to 0. Reset takes priority over MemWrite.
//  - Write: on a rising edge with Reset=0 and MemWrite=1, mem[index] <= WriteData.
//    - Write latency is one edge; the new value is readable immediately after that edge.
//  - Read: ReadData = MemRead ? mem[index] : 0, purely combinational with zero-cycle latency.
//    - No clock edge is needed; Adresa or MemRead changes propagate within the same cycle.
//  - MemRead=0 forces ReadData to 0, including during and after reset.
//  - MemRead and MemWrite both 1 on the same index:
//    - before the edge, ReadData shows the old word;
//    - after the edge, ReadData shows WriteData.
//    - There is no write-to-read bypass.
//  - Output values:
//    - ReadData is 0 whenever MemRead=0.
//    - After reset, ReadData is 0 for any address.
//    - Power-up contents are undefined until the first reset.
//  - Inputs with X/Z are not handled specially. No handshake; every access completes in one cycle.
// CONFIGURATION
//  DMEM_RANGE_CHECK_EN defined:
//    - AddrErr = (Adresa >= DEPTH), combinational.
//    - When AddrErr=1, writes are suppressed and ReadData is 0 (no wrap).
//  DMEM_RANGE_CHECK_EN undefined:
//    - Address wraps modulo DEPTH.
//    - The AddrErr port is still present and is tied to 0.
// STRUCTURE
//  Package dmem_pkg holds:
//    - localparams DMEM_DATA_W=16, DMEM_ADDR_W=16, DMEM_DEPTH=256;
//    - typedef dmem_word_t (logic [DATA_W-1:0]).
//  Sub-module dmem_array (storage, write port with sync clear, async read port).
//  The top handles index and range logic plus read gating.
// TESTING
//  1. Reset=1 for one edge; MemRead=1, Adresa=13 -> ReadData=0x0000.
//  2. MemWrite=1, Adresa=13, WriteData=0x00FF, one edge; then MemWrite=0, MemRead=1 with no further edge -> ReadData=0x00FF.
//  3. Same state as scenario 2, MemRead=0 -> ReadData=0x0000; set MemRead=1 again -> 0x00FF with no clock edge.
//  4. MemWrite=1, MemRead=1, Adresa=13, WriteData=0x1234 -> ReadData=0x00FF before the edge, 0x1234 after it.
//  5. Write 0xBEEF to address 5; assert Reset together with MemWrite=1 on one edge -> address 5 reads 0x0000 (reset wins).
//  6. Write 0xA5A5 to Adresa=269 (256+13):
//    - macro undefined -> Adresa=13 reads 0xA5A5;
//    - macro defined -> AddrErr=1, address 13 keeps its prior value, ReadData at 269 is 0x0000.

Source files
------------

// File: rtl/data_memory_pkg.sv
// Shared widths and word type for the CPU-16 data memory.
// No logic; constants and types only.
// Imported by the memory interface, storage array, top and bench.
package dmem_pkg;

    localparam int DMEM_DATA_W = 16;
    localparam int DMEM_ADDR_W = 16;
    localparam int DMEM_DEPTH  = 256;

    typedef logic [DMEM_DATA_W-1:0] dmem_word_t;

endpackage : dmem_pkg

// File: rtl/data_memory_if.sv
// MEM-stage bus between the datapath (master) and the data memory (slave).
// Latency: none of its own; a wire bundle.
// Backpressure: none, every access completes in one cycle.
interface data_memory_if
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int ADDR_W = DMEM_ADDR_W
);

    logic [ADDR_W-1:0] Adresa;
    logic [DATA_W-1:0] WriteData;
    logic              MemWrite;
    logic              MemRead;
    logic [DATA_W-1:0] ReadData;
    logic              AddrErr;

    modport master (
        output Adresa,
        output WriteData,
        output MemWrite,
        output MemRead,
        input  ReadData,
        input  AddrErr
    );

    modport slave (
        input  Adresa,
        input  WriteData,
        input  MemWrite,
        input  MemRead,
        output ReadData,
        output AddrErr
    );

endinterface : data_memory_if

// File: rtl/data_memory_array.sv
// Word storage: one synchronous write port with synchronous clear, one async read port.
// Latency: write lands on the rising edge; read is combinational (zero cycles).
// Backpressure: none; no write-to-read bypass, a same-edge read sees the old word.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int DEPTH  = DMEM_DEPTH,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // Next contents: unchanged except the addressed word on a write.
    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    // Storage register; clear wins over a coincident write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : dmem_array

// File: rtl/data_memory.sv
// Word-addressed data memory for the MEM stage (DEPTH must be a power of two, at most 2**ADDR_W).
// Latency: write on the rising Clock edge; read combinational, gated by MemRead.
// Backpressure: none. DMEM_RANGE_CHECK_EN: flag out-of-range addresses instead of wrapping.
module data_memory
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DEPTH  = DMEM_DEPTH
) (
    input  logic                Clock,
    input  logic                Reset,
    data_memory_if.slave        bus
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [IDX_W-1:0]  idx;
    logic              addr_err;
    logic              wr_en;
    logic [DATA_W-1:0] arr_rdata;
    logic              unused_addr_bits;

    // Upper address bits only matter for the range check; otherwise they wrap away.
    assign idx              = bus.Adresa[IDX_W-1:0];
    assign unused_addr_bits = ^bus.Adresa;

`ifdef DMEM_RANGE_CHECK_EN
    // Widen by one bit so DEPTH == 2**ADDR_W compares correctly.
    assign addr_err = ({1'b0, bus.Adresa} >= (ADDR_W+1)'(DEPTH));
`else
    assign addr_err = 1'b0;
`endif

    assign wr_en = bus.MemWrite & ~addr_err;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk_i   (Clock),
        .rst_i   (Reset),
        .we_i    (wr_en),
        .waddr_i (idx),
        .wdata_i (bus.WriteData),
        .raddr_i (idx),
        .rdata_o (arr_rdata)
    );

    // Read data is forced to zero unless a valid, enabled read is in progress.
    always_comb begin
        bus.ReadData = '0;
        if (bus.MemRead && !addr_err) begin
            bus.ReadData = arr_rdata;
        end
    end

    assign bus.AddrErr = addr_err;

endmodule : data_memory

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: reset, write/read, read gating, same-edge read/write,
// reset-over-write priority, index boundaries and the out-of-range/wrap behaviour.
module tb_data_memory;
    import dmem_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    data_memory_if #(.DATA_W(DMEM_DATA_W), .ADDR_W(DMEM_ADDR_W)) bus ();

    data_memory #(
        .DATA_W (DMEM_DATA_W),
        .ADDR_W (DMEM_ADDR_W),
        .DEPTH  (DMEM_DEPTH)
    ) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge and settle before anything is sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [15:0] addr, input dmem_word_t data);
        bus.Adresa    = addr;
        bus.WriteData = data;
        bus.MemWrite  = 1'b1;
        tick();
        bus.MemWrite  = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [15:0] addr, input dmem_word_t exp);
        bus.Adresa  = addr;
        bus.MemRead = 1'b1;
        #1;
        check(tag, 32'(bus.ReadData), 32'(exp));
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.Adresa    = 16'd13;
        bus.WriteData = 16'h0000;
        bus.MemWrite  = 1'b0;
        bus.MemRead   = 1'b0;

        // 1: reset clears; read gating off gives zero, enabled read also zero
        tick();
        rst = 1'b0;
        #1;
        check("rst_rd_off", 32'(bus.ReadData), 32'h0);
        check("rst_adderr", 32'(bus.AddrErr), 32'h0);
        read_check("rst_rd13", 16'd13, 16'h0000);
        read_check("rst_rd255", 16'd255, 16'h0000);

        // 2: write then read without another edge
        bus.MemRead = 1'b0;
        write_word(16'd13, 16'h00FF);
        read_check("wr_rd13", 16'd13, 16'h00FF);

        // 3: MemRead gating is combinational
        bus.MemRead = 1'b0;
        #1;
        check("gate_off", 32'(bus.ReadData), 32'h0);
        bus.MemRead = 1'b1;
        #1;
        check("gate_on", 32'(bus.ReadData), 32'h00FF);

        // 4: same-index read+write: old before edge, new after
        bus.Adresa    = 16'd13;
        bus.WriteData = 16'h1234;
        bus.MemWrite  = 1'b1;
        #1;
        check("rw_before", 32'(bus.ReadData), 32'h00FF);
        tick();
        bus.MemWrite = 1'b0;
        check("rw_after", 32'(bus.ReadData), 32'h1234);

        // Index boundaries and independence of neighbouring words
        write_word(16'd0,   16'hC0DE);
        write_word(16'd255, 16'hFACE);
        read_check("bnd_rd0", 16'd0, 16'hC0DE);
        read_check("bnd_rd255", 16'd255, 16'hFACE);
        read_check("bnd_rd13", 16'd13, 16'h1234);
        read_check("bnd_rd1", 16'd1, 16'h0000);

        // 5: reset wins over a coincident write
        write_word(16'd5, 16'hBEEF);
        read_check("pre_rst5", 16'd5, 16'hBEEF);
        bus.WriteData = 16'hBEEF;
        bus.MemWrite  = 1'b1;
        rst           = 1'b1;
        tick();
        rst          = 1'b0;
        bus.MemWrite = 1'b0;
        read_check("rstwin5", 16'd5, 16'h0000);
        read_check("rstwin255", 16'd255, 16'h0000);

        // 6: out-of-range address 269 = 256 + 13
        write_word(16'd13, 16'h1111);
        write_word(16'd269, 16'hA5A5);
`ifdef DMEM_RANGE_CHECK_EN
        read_check("oor_rd269", 16'd269, 16'h0000);
        check("oor_err269", 32'(bus.AddrErr), 32'h1);
        read_check("oor_rd13", 16'd13, 16'h1111);
        check("oor_err13", 32'(bus.AddrErr), 32'h0);
        bus.Adresa = 16'hFFFF;
        #1;
        check("oor_errffff", 32'(bus.AddrErr), 32'h1);
`else
        read_check("wrap_rd13", 16'd13, 16'hA5A5);
        check("wrap_err13", 32'(bus.AddrErr), 32'h0);
        read_check("wrap_rd269", 16'd269, 16'hA5A5);
        check("wrap_err269", 32'(bus.AddrErr), 32'h0);
        read_check("wrap_rdffff", 16'hFFFF, 16'h0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_data_memory
